// File: rtl/ram_copy_dma.sv
// Purpose : word-at-a-time DMA over an async-read RAM. It either copies src->dst
//           (memmove-safe direction) or fills dst with a pattern.
// Latency : start edge to done cycle is 2*len+1 for copy, len+1 for fill, 1 for len=0.
// Backpr. : none; start is taken only in IDLE and ignored while busy (no queuing).
// Ports   : clk, reset (async, active-high); command start/fill/src/dst/len/pattern;
//           status busy/done; RAM side mem_address/mem_in/mem_load out, mem_out in.
module ram_copy_dma #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          fill,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_in,
  output logic          mem_load,
  input  logic [DW-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  state_t        state, state_nx;
  logic          fill_r;
  logic          desc_r;
  logic [AW-1:0] src_r;
  logic [AW-1:0] dst_r;
  logic [AW:0]   len_r;
  logic [DW-1:0] pattern_r;
  logic [DW-1:0] data_r;
  logic [AW:0]   i_r;     // one bit wider than AW so len=256 terminates cleanly
  logic [AW:0]   off_full;
  logic [AW-1:0] off;
  logic          last;

  // Descending order prevents an overlapping copy from reading words it has
  // already overwritten when the destination sits above the source.
  always_comb begin
    off_full = i_r;
    if (desc_r) off_full = len_r - ONE - i_r;
  end
  assign off  = off_full[AW-1:0];
  assign last = ((i_r + ONE) == len_r);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) state_nx = DONE;
          else if (fill) state_nx = WRITE;
          else           state_nx = READ;
        end
      end
      READ:  state_nx = WRITE;
      WRITE: begin
        if (last)        state_nx = DONE;
        else if (fill_r) state_nx = WRITE;
        else             state_nx = READ;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic. The outputs are decoded from the state alone, so reset clears them at once.
  always_comb begin
    busy        = (state != IDLE);
    done        = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    case (state)
      READ: begin
        mem_address = src_r + off;
      end
      WRITE: begin
        mem_address = dst_r + off;
        mem_in      = fill_r ? pattern_r : data_r;
        mem_load    = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Command registers, word counter and read-data holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_r    <= 1'b0;
      desc_r    <= 1'b0;
      src_r     <= '0;
      dst_r     <= '0;
      len_r     <= '0;
      pattern_r <= '0;
      data_r    <= '0;
      i_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            fill_r    <= fill;
            desc_r    <= !fill && (dst > src);
            src_r     <= src;
            dst_r     <= dst;
            len_r     <= len;
            pattern_r <= pattern;
            i_r       <= '0;
          end
        end
        READ:  data_r <= mem_out;
        WRITE: i_r    <= i_r + ONE;
        default: ;
      endcase
    end
  end

endmodule
